// File: rtl/atm_key_conditioner_pkg.sv
// Shared constants for the ATM key conditioner.
//   SYNC_STAGES             : flops in each raw-input synchroniser
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count before acceptance
//   NUM_CH / CH_*           : channel count and channel indices
package atm_key_conditioner_pkg;
  localparam int SYNC_STAGES             = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000;
  localparam int NUM_CH                  = 3;
  localparam int CH_CARD                 = 0;
  localparam int CH_A                    = 1;
  localparam int CH_B                    = 2;
endpackage

// File: rtl/atm_key_conditioner_if.sv
// Signal bundle between the raw switch/keys and the PIN-check FSM.
//   card_raw, key_a_raw, key_b_raw : asynchronous raw inputs
//   card                           : debounced card-present level
//   a, b                           : one-cycle accepted key pulses
//   key_conflict                   : one-cycle pulse on simultaneous A+B
// master = stimulus side, slave = conditioner.
interface atm_key_conditioner_if;
  logic card_raw;
  logic key_a_raw;
  logic key_b_raw;
  logic card;
  logic a;
  logic b;
  logic key_conflict;

  modport master (output card_raw, key_a_raw, key_b_raw,
                  input  card, a, b, key_conflict);
  modport slave  (input  card_raw, key_a_raw, key_b_raw,
                  output card, a, b, key_conflict);
endinterface

// File: rtl/atm_key_conditioner_debounce.sv
// key_debounce: synchroniser + stable-count debouncer for one raw input.
//   clk, nrst    : clock, synchronous active-low reset
//   raw          : asynchronous input
//   stable       : debounced level
//   accept_rise  : high during the cycle whose edge accepts a 0->1 change
module key_debounce
  import atm_key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw,
  output logic stable,
  output logic accept_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];
  // accept is the condition that the coming edge commits synced into stable;
  // the top registers its pulses on that same edge.
  assign accept      = (synced != stable) && (cnt == CNT_MAX);
  assign accept_rise = accept & synced;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Any return to the stable value restarts the full count.
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/atm_key_conditioner.sv
// atm_key_conditioner: debounces card switch and keys A/B, emits a clean
// card level and single-cycle a/b pulses, flags simultaneous A+B presses.
//   clk  : system clock
//   nrst : synchronous active-low reset
//   bus  : slave side of atm_key_conditioner_if (raw inputs, conditioned outputs)
module atm_key_conditioner
  import atm_key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  nrst,
  atm_key_conditioner_if.slave  bus
);
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] rise;
  logic              a_q, b_q, conflict_q;
  logic              unused_chan;

  assign raw[CH_CARD] = bus.card_raw;
  assign raw[CH_A]    = bus.key_a_raw;
  assign raw[CH_B]    = bus.key_b_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk         (clk),
      .nrst        (nrst),
      .raw         (raw[i]),
      .stable      (stable[i]),
      .accept_rise (rise[i])
    );
  end

  // Key levels and card rising-accept carry no meaning downstream.
  assign unused_chan = stable[CH_A] ^ stable[CH_B] ^ rise[CH_CARD];

  // Gating uses the card level before the edge, so a key accepted on the
  // same edge the card is accepted is consumed silently.
  always_ff @(posedge clk) begin
    if (!nrst || !stable[CH_CARD]) begin
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else if (rise[CH_A] && rise[CH_B]) begin
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      conflict_q <= 1'b1;
    end else begin
      a_q        <= rise[CH_A];
      b_q        <= rise[CH_B];
      conflict_q <= 1'b0;
    end
  end

  assign bus.card         = stable[CH_CARD];
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.key_conflict = conflict_q;
endmodule

// File: tb/tb_atm_key_conditioner.sv
// Self-checking bench for atm_key_conditioner with DEBOUNCE_CYCLES = 4.
// A behavioural model (sample history + run-length debounce) predicts the
// outputs after every edge; directed scenarios add literal expectations.
module tb_atm_key_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic nrst;
  atm_key_conditioner_if bus ();

  atm_key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  // synced before edge n equals the raw value sampled at edge n-2; a channel
  // is accepted once synced has differed from the accepted level for D
  // consecutive edges.
  logic [2:0] smp1, smp2, m_stable, m_rise, raw_v, synced_v;
  int         run [3];
  logic       card_before;
  logic       exp_card = 0, exp_a = 0, exp_b = 0, exp_conf = 0;

  always @(posedge clk) begin
    cyc++;
    raw_v = {bus.key_b_raw, bus.key_a_raw, bus.card_raw};
    if (!nrst) begin
      smp1 = '0; smp2 = '0; m_stable = '0;
      for (int c = 0; c < 3; c++) run[c] = 0;
      exp_card = 0; exp_a = 0; exp_b = 0; exp_conf = 0;
    end else begin
      synced_v    = smp2;
      card_before = m_stable[0];
      m_rise      = '0;
      for (int c = 0; c < 3; c++) begin
        if (synced_v[c] == m_stable[c]) run[c] = 0;
        else begin
          run[c]++;
          if (run[c] == D) begin
            m_stable[c] = synced_v[c];
            run[c] = 0;
            m_rise[c] = synced_v[c];
          end
        end
      end
      exp_card = m_stable[0];
      exp_conf = card_before & m_rise[1] & m_rise[2];
      exp_a    = card_before & m_rise[1] & ~m_rise[2];
      exp_b    = card_before & m_rise[2] & ~m_rise[1];
      smp2 = smp1;
      smp1 = raw_v;
    end
  end

  // ---------------- compare + pulse monitor ----------------
  int   a_cnt = 0, b_cnt = 0, conf_cnt = 0;
  int   last_a = -1, last_b = -1, card_rise = -1;
  logic card_prev = 0;

  always @(negedge clk) begin
    check("outputs_vs_model",
          int'({bus.card, bus.a, bus.b, bus.key_conflict}),
          int'({exp_card, exp_a, exp_b, exp_conf}));
    check("pulse_exclusive",
          int'(bus.a) + int'(bus.b) + int'(bus.key_conflict) <= 1, 1);
    if (bus.a === 1'b1) begin a_cnt++; last_a = cyc; end
    if (bus.b === 1'b1) begin b_cnt++; last_b = cyc; end
    if (bus.key_conflict === 1'b1) conf_cnt++;
    if (bus.card === 1'b1 && !card_prev) card_rise = cyc;
    card_prev = (bus.card === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int k, a0, b0, c0;
  int hold [3];
  logic [2:0] rv;

  initial begin
    nrst = 1'b0;
    bus.card_raw = 1'b1; bus.key_a_raw = 1'b1; bus.key_b_raw = 1'b1;
    idle(10);
    check("reset_outputs",
          int'({bus.card, bus.a, bus.b, bus.key_conflict}), 0);

    // Release reset with everything held: card after 6 edges, keys consumed.
    nrst = 1'b1; k = cyc + 1;
    idle(10);
    check("reset_card_rise_edge", card_rise, k + 5);
    check("reset_no_key_pulse", a_cnt + b_cnt + conf_cnt, 0);
    bus.key_a_raw = 1'b0; bus.key_b_raw = 1'b0;
    idle(12);

    // Clean key A held 30 cycles.
    a0 = a_cnt; bus.key_a_raw = 1'b1; k = cyc + 1;
    idle(30);
    check("clean_a_one_pulse", a_cnt, a0 + 1);
    check("clean_a_pulse_edge", last_a, k + 5);
    check("clean_a_no_b", b_cnt, 0);
    bus.key_a_raw = 1'b0;
    idle(12);
    check("clean_a_no_release_pulse", a_cnt, a0 + 1);

    // Bouncy key B: toggles every 2 cycles for 12 cycles, then holds 1.
    b0 = b_cnt;
    for (int i = 0; i < 12; i++) begin
      bus.key_b_raw = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    bus.key_b_raw = 1'b1; k = cyc + 1;
    idle(20);
    check("bouncy_b_one_pulse", b_cnt, b0 + 1);
    check("bouncy_b_pulse_edge", last_b, k + 5);
    bus.key_b_raw = 1'b0;
    idle(12);

    // Simultaneous press.
    a0 = a_cnt; b0 = b_cnt; c0 = conf_cnt;
    bus.key_a_raw = 1'b1; bus.key_b_raw = 1'b1;
    idle(20);
    check("simul_conflict_pulse", conf_cnt, c0 + 1);
    check("simul_no_ab", (a_cnt - a0) + (b_cnt - b0), 0);
    bus.key_a_raw = 1'b0; bus.key_b_raw = 1'b0;
    idle(12);

    // No card: press consumed, held key across insertion consumed.
    a0 = a_cnt;
    bus.card_raw = 1'b0; idle(12);
    bus.key_a_raw = 1'b1; idle(12);
    check("nocard_no_a", a_cnt, a0);
    bus.card_raw = 1'b1; idle(12);
    check("nocard_card_up", int'(bus.card), 1);
    check("nocard_held_no_a", a_cnt, a0);
    bus.key_a_raw = 1'b0; idle(12);
    bus.key_a_raw = 1'b1; idle(12);
    check("nocard_repress_a", a_cnt, a0 + 1);
    bus.key_a_raw = 1'b0; idle(12);

    // Reset at edge k+4 of a press: partial count lost; the card is also
    // re-accepted on the same edge as the held key, so that key is consumed.
    a0 = a_cnt;
    bus.key_a_raw = 1'b1; k = cyc + 1;
    idle(4);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1; k = cyc + 1;
    idle(12);
    check("midreset_no_a", a_cnt, a0);
    check("midreset_card_edge", card_rise, k + 5);
    bus.key_a_raw = 1'b0; idle(12);
    bus.key_a_raw = 1'b1; idle(12);
    check("midreset_repress_a", a_cnt, a0 + 1);

    // Randomised bouncing on all three channels with occasional reset.
    for (int c = 0; c < 3; c++) hold[c] = 0;
    rv = {bus.key_b_raw, bus.key_a_raw, bus.card_raw};
    for (int n = 0; n < 5000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          rv[c] = ~rv[c];
          hold[c] = (c == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 10));
        end else hold[c]--;
      end
      bus.card_raw = rv[0]; bus.key_a_raw = rv[1]; bus.key_b_raw = rv[2];
      nrst = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    nrst = 1'b1;
    idle(4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
